aukv_mem_arbiter: RTL and testbench
===================================

# aukv_mem_arbiter

Two-requester arbiter that shares the single AUK-V memory port between instruction fetch and the memory-access stage. It serialises requests onto one bus with one outstanding transaction, round-robin fairness and a response timeout. It returns a registered, single-cycle valid pulse to the granted requester, which stalls until then. It sits between the core (fetch and memory stages) and the unified memory or bus bridge.

## Interface
- TIMEOUT, 64, number of WAIT cycles without `i_bus_valid` before the transaction is terminated with an error (≥2)
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_ins_req  in  1  fetch request, level, held until `o_ins_valid`
- i_ins_addr  in  32  fetch address; stable while `i_ins_req`=1
- i_ins_cancel  in  1  drop the fetch response (branch flush)
- o_ins_data  out  32  fetch read data
- o_ins_valid  out  1  one-cycle fetch response pulse
- o_ins_err  out  1  fetch timed out; qualifies `o_ins_valid`
- i_dat_req  in  1  data request, level, held until `o_dat_valid`
- i_dat_we  in  1  1 = store, 0 = load
- i_dat_addr  in  32  data address
- i_dat_wdata  in  32  store data
- i_dat_strobe  in  4  byte strobe
- o_dat_rdata  out  32  load data
- o_dat_valid  out  1  one-cycle data response pulse
- o_dat_err  out  1  data timed out; qualifies `o_dat_valid`
- o_bus_en  out  1  one-cycle transaction start pulse
- o_bus_we  out  1  write enable; held for the whole transaction
- o_bus_addr  out  32  held for the whole transaction
- o_bus_wdata  out  32  held for the whole transaction
- o_bus_strobe  out  4  held for the whole transaction; fetch always drives 4'hf
- i_bus_rdata  in  32  read data; sampled when `i_bus_valid`=1
- i_bus_valid  in  1  one-cycle completion pulse
- o_busy  out  1  1 in any state other than IDLE

## Operation
- FSM states are IDLE, WAIT and RESP. Grant pointer `last` is 1 bit: 0 = INS granted last, 1 = DAT granted last.
- **IDLE**
  - If no request, stay in IDLE.
  - If exactly one of `i_ins_req` or `i_dat_req` is high, grant it.
  - If both are high, grant the requester that was not granted last. After reset `last`=INS, so DAT wins the first tie.
  - On grant:
    - latch addr, we, wdata and strobe into the bus registers;
    - set `o_bus_en`=1 for the next cycle;
    - clear the timeout counter, update `last` and store `gnt`;
    - go to WAIT.
  - A fetch grant always drives we=0 and strobe=4'hf.
- **WAIT**
  - `o_bus_en` is 1 only in the first WAIT cycle. Bus address/data/we/strobe stay constant.
  - On `i_bus_valid`: latch `i_bus_rdata` into the granted requester's data output, set err=0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT-1: the data output is 0, err=1, go to RESP.
  - Otherwise the counter increments. The counter width is clog2(TIMEOUT)+1 and it never wraps.
- **RESP**
  - The granted requester's `o_*_valid`=1 for exactly this cycle, then the FSM returns to IDLE.
  - The requester updates its request at the edge that ends RESP, so IDLE sees the new or deasserted request.
- **Cancel**
  - If `i_ins_cancel`=1 in any cycle while INS is granted (WAIT or RESP), set a sticky `drop` flag. `drop` clears on return to IDLE.
  - With `drop` set, the bus transaction still completes normally, but `o_ins_valid` and `o_ins_err` are forced to 0 in RESP.
  - Cancel in IDLE, or while DAT is granted, has no effect.
- The data outputs (`o_ins_data`, `o_dat_rdata`) hold their last value outside RESP.
- A store returns `o_dat_valid` with `o_dat_rdata`=`i_bus_rdata` (don't care).
- `i_bus_valid` outside WAIT is ignored; there is no state change and no response.

## Timing
- Reset values:
  - all outputs are 0; state is IDLE, `last`=INS, `drop`=0, counter=0;
  - `o_bus_strobe`=0, `o_bus_addr`=0, `o_ins_data`=0, `o_dat_rdata`=0.
- Reset in WAIT or RESP aborts immediately: no valid pulse is produced, and a later stray `i_bus_valid` is ignored.
- All outputs are registered; there is no combinational path from input to output.
- The request is seen in IDLE at cycle t. Then:
  - `o_bus_en`=1 in cycle t+1;
  - `i_bus_valid` is legal from cycle t+1 onward, including the same cycle as `o_bus_en`;
  - if valid arrives in cycle v, `o_*_valid`=1 in cycle v+1, then IDLE at v+2.
- Minimum request-to-response time is 2 cycles, and a back-to-back transaction occupies 3 cycles.
- Timeout: a request in IDLE at cycle t gives the err response in cycle t+TIMEOUT+1.
- Requesters must keep req and the payload stable from assertion until the cycle of their valid pulse.

## Test plan
- Single load: DAT req addr=0x100, strobe=4'hf; memory returns valid 3 cycles after en with rdata=0xDEADBEEF.
  - Required: `o_bus_en` pulses 1 cycle, `o_dat_valid`=1 for one cycle with 0xDEADBEEF, `o_ins_valid` stays 0, `o_busy` falls 2 cycles after `i_bus_valid`.
- Simultaneous requests from reset: INS addr=0x0 and DAT addr=0x200, both held, zero-wait memory.
  - Required grant order is DAT, INS, DAT, INS; each transaction is 3 cycles; the bus address alternates 0x200, 0x0.
- Store: we=1, wdata=0x12345678, strobe=4'h3.
  - Required: bus we, wdata and strobe are constant across all WAIT cycles; `o_dat_valid`=1, `o_dat_err`=0.
- Timeout with TIMEOUT=8 and memory never valid on an INS fetch.
  - Required: `o_ins_valid`=1, `o_ins_err`=1, `o_ins_data`=0 in cycle t+9; the FSM returns to IDLE.
  - A stray `i_bus_valid` afterwards produces no response.
- Cancel: pulse `i_ins_cancel` for 1 cycle during an INS WAIT.
  - Required: the bus completes, no `o_ins_valid`, and a pending DAT request is granted in the next IDLE.
- Reset mid-WAIT: assert `i_rst` for 1 cycle.
  - Required: all outputs are 0 on the next cycle, a subsequent `i_bus_valid` is ignored, and a tie after reset grants DAT first.

Source files
------------

// File: rtl/aukv_mem_arbiter.sv
// Shares the single AUK-V memory port between fetch and the memory stage:
// one outstanding transaction, round-robin on ties, response timeout.
module aukv_mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ins_req,
  input  logic [31:0] i_ins_addr,
  input  logic        i_ins_cancel,
  output logic [31:0] o_ins_data,
  output logic        o_ins_valid,
  output logic        o_ins_err,
  input  logic        i_dat_req,
  input  logic        i_dat_we,
  input  logic [31:0] i_dat_addr,
  input  logic [31:0] i_dat_wdata,
  input  logic [3:0]  i_dat_strobe,
  output logic [31:0] o_dat_rdata,
  output logic        o_dat_valid,
  output logic        o_dat_err,
  output logic        o_bus_en,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_strobe,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_valid,
  output logic        o_busy
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
  } bus_req_t;

  state_t          state;
  logic            last;   // 1 = DAT granted last
  logic            gnt;    // 1 = DAT owns the current transaction
  logic            drop;
  logic [CW-1:0]   cnt;
  bus_req_t        bus_q;
  bus_req_t        nxt_req;
  logic            pick_dat;
  logic            tmo;
  logic            ins_kill;

  always_comb begin
    pick_dat = i_dat_req && (!i_ins_req || !last);
    nxt_req  = pick_dat ? '{we: i_dat_we, addr: i_dat_addr, wdata: i_dat_wdata, strobe: i_dat_strobe}
                        : '{we: 1'b0, addr: i_ins_addr, wdata: 32'h0, strobe: 4'hf};
    tmo      = (cnt == CW'(TIMEOUT - 1));
    // a cancel in the final WAIT cycle must still suppress the registered pulse
    ins_kill = drop || i_ins_cancel;
  end

  assign o_bus_we     = bus_q.we;
  assign o_bus_addr   = bus_q.addr;
  assign o_bus_wdata  = bus_q.wdata;
  assign o_bus_strobe = bus_q.strobe;
  assign o_busy       = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      last        <= 1'b0;
      gnt         <= 1'b0;
      drop        <= 1'b0;
      cnt         <= '0;
      bus_q       <= '0;
      o_bus_en    <= 1'b0;
      o_ins_data  <= '0;
      o_ins_valid <= 1'b0;
      o_ins_err   <= 1'b0;
      o_dat_rdata <= '0;
      o_dat_valid <= 1'b0;
      o_dat_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_ins_req || i_dat_req) begin
            bus_q    <= nxt_req;
            o_bus_en <= 1'b1;
            cnt      <= '0;
            last     <= pick_dat;
            gnt      <= pick_dat;
            drop     <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          o_bus_en <= 1'b0;
          if (!gnt && i_ins_cancel) drop <= 1'b1;
          if (i_bus_valid || tmo) begin
            state <= RESP;
            if (gnt) begin
              o_dat_rdata <= i_bus_valid ? i_bus_rdata : 32'h0;
              o_dat_valid <= 1'b1;
              o_dat_err   <= !i_bus_valid;
            end else begin
              o_ins_data  <= i_bus_valid ? i_bus_rdata : 32'h0;
              o_ins_valid <= !ins_kill;
              o_ins_err   <= !ins_kill && !i_bus_valid;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          o_ins_valid <= 1'b0;
          o_ins_err   <= 1'b0;
          o_dat_valid <= 1'b0;
          o_dat_err   <= 1'b0;
          drop        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aukv_mem_arbiter.sv
// Directed bench for aukv_mem_arbiter: vector table plus hand-written
// sequences for reset-abort, tie ordering and timeout.
module tb_aukv_mem_arbiter;
  logic        clk;
  logic        rst;
  logic        ins_req;
  logic [31:0] ins_addr;
  logic        ins_cancel;
  logic [31:0] ins_data;
  logic        ins_valid;
  logic        ins_err;
  logic        dat_req;
  logic        dat_we;
  logic [31:0] dat_addr;
  logic [31:0] dat_wdata;
  logic [3:0]  dat_strobe;
  logic [31:0] dat_rdata;
  logic        dat_valid;
  logic        dat_err;
  logic        bus_en;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strobe;
  logic [31:0] bus_rdata;
  logic        bus_valid;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  aukv_mem_arbiter #(.TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ins_req(ins_req), .i_ins_addr(ins_addr), .i_ins_cancel(ins_cancel),
    .o_ins_data(ins_data), .o_ins_valid(ins_valid), .o_ins_err(ins_err),
    .i_dat_req(dat_req), .i_dat_we(dat_we), .i_dat_addr(dat_addr),
    .i_dat_wdata(dat_wdata), .i_dat_strobe(dat_strobe),
    .o_dat_rdata(dat_rdata), .o_dat_valid(dat_valid), .o_dat_err(dat_err),
    .o_bus_en(bus_en), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
    .o_bus_wdata(bus_wdata), .o_bus_strobe(bus_strobe),
    .i_bus_rdata(bus_rdata), .i_bus_valid(bus_valid), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        cx;
    logic        dr;
    logic        we;
    logic [31:0] da;
    logic [31:0] wd;
    logic [3:0]  st;
    logic        bv;
    logic [31:0] rd;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [3:0]  e_st;
    logic        e_iv;
    logic        e_ie;
    logic [31:0] e_id;
    logic        e_dv;
    logic        e_de;
    logic [31:0] e_dd;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    rst = 0; ins_req = 0; ins_addr = 0; ins_cancel = 0;
    dat_req = 0; dat_we = 0; dat_addr = 0; dat_wdata = 0; dat_strobe = 0;
    bus_valid = 0; bus_rdata = 0;
  endtask

  initial begin
    clr_in();
    rst = 1;
    // rst ir ia cx dr we da wd st bv rd | en we addr wd st iv ie id dv de dd busy
    vq.push_back(vec_t'{1,0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,0,0,0,0,0});
    // single load, valid 3 cycles after en
    vq.push_back(vec_t'{0,0,0,0,1,0,32'h100,0,4'hf,0,0,   1,0,32'h100,0,4'hf,0,0,0,0,0,0,1});
    vq.push_back(vec_t'{0,0,0,0,1,0,32'h100,0,4'hf,0,0,   0,0,32'h100,0,4'hf,0,0,0,0,0,0,1});
    vq.push_back(vec_t'{0,0,0,0,1,0,32'h100,0,4'hf,0,0,   0,0,32'h100,0,4'hf,0,0,0,0,0,0,1});
    vq.push_back(vec_t'{0,0,0,0,1,0,32'h100,0,4'hf,0,0,   0,0,32'h100,0,4'hf,0,0,0,0,0,0,1});
    vq.push_back(vec_t'{0,0,0,0,1,0,32'h100,0,4'hf,1,32'hDEADBEEF, 0,0,32'h100,0,4'hf,0,0,0,1,0,32'hDEADBEEF,1});
    vq.push_back(vec_t'{0,0,0,0,1,0,32'h100,0,4'hf,0,0,   0,0,32'h100,0,4'hf,0,0,0,0,0,32'hDEADBEEF,0});
    vq.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0,0,            0,0,32'h100,0,4'hf,0,0,0,0,0,32'hDEADBEEF,0});
    // store
    vq.push_back(vec_t'{0,0,0,0,1,1,32'h300,32'h12345678,4'h3,0,0, 1,1,32'h300,32'h12345678,4'h3,0,0,0,0,0,32'hDEADBEEF,1});
    vq.push_back(vec_t'{0,0,0,0,1,1,32'h300,32'h12345678,4'h3,0,0, 0,1,32'h300,32'h12345678,4'h3,0,0,0,0,0,32'hDEADBEEF,1});
    vq.push_back(vec_t'{0,0,0,0,1,1,32'h300,32'h12345678,4'h3,0,0, 0,1,32'h300,32'h12345678,4'h3,0,0,0,0,0,32'hDEADBEEF,1});
    vq.push_back(vec_t'{0,0,0,0,1,1,32'h300,32'h12345678,4'h3,1,32'hAAAA5555, 0,1,32'h300,32'h12345678,4'h3,0,0,0,1,0,32'hAAAA5555,1});
    vq.push_back(vec_t'{0,0,0,0,1,1,32'h300,32'h12345678,4'h3,0,0, 0,1,32'h300,32'h12345678,4'h3,0,0,0,0,0,32'hAAAA5555,0});
    vq.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0,0,            0,1,32'h300,32'h12345678,4'h3,0,0,0,0,0,32'hAAAA5555,0});
    // fetch cancelled mid-WAIT, DAT pending behind it
    vq.push_back(vec_t'{0,1,32'h40,0,0,0,0,0,0,0,0,       1,0,32'h40,0,4'hf,0,0,0,0,0,32'hAAAA5555,1});
    vq.push_back(vec_t'{0,1,32'h40,1,1,0,32'h500,0,4'hf,0,0, 0,0,32'h40,0,4'hf,0,0,0,0,0,32'hAAAA5555,1});
    vq.push_back(vec_t'{0,1,32'h40,0,1,0,32'h500,0,4'hf,0,0, 0,0,32'h40,0,4'hf,0,0,0,0,0,32'hAAAA5555,1});
    vq.push_back(vec_t'{0,1,32'h40,0,1,0,32'h500,0,4'hf,1,0, 0,0,32'h40,0,4'hf,0,0,0,0,0,32'hAAAA5555,1});
    vq.push_back(vec_t'{0,0,0,0,1,0,32'h500,0,4'hf,0,0,   0,0,32'h40,0,4'hf,0,0,0,0,0,32'hAAAA5555,0});
    vq.push_back(vec_t'{0,0,0,0,1,0,32'h500,0,4'hf,0,0,   1,0,32'h500,0,4'hf,0,0,0,0,0,32'hAAAA5555,1});
    vq.push_back(vec_t'{0,0,0,0,1,0,32'h500,0,4'hf,1,32'hCAFEF00D, 0,0,32'h500,0,4'hf,0,0,0,1,0,32'hCAFEF00D,1});
    vq.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0,0,            0,0,32'h500,0,4'hf,0,0,0,0,0,32'hCAFEF00D,0});

    foreach (vq[i]) begin
      rst = vq[i].rst; ins_req = vq[i].ir; ins_addr = vq[i].ia; ins_cancel = vq[i].cx;
      dat_req = vq[i].dr; dat_we = vq[i].we; dat_addr = vq[i].da; dat_wdata = vq[i].wd;
      dat_strobe = vq[i].st; bus_valid = vq[i].bv; bus_rdata = vq[i].rd;
      step();
      chk($sformatf("row%0d.bus_en", i),    32'(bus_en),     32'(vq[i].e_en));
      chk($sformatf("row%0d.bus_we", i),    32'(bus_we),     32'(vq[i].e_we));
      chk($sformatf("row%0d.bus_addr", i),  bus_addr,        vq[i].e_addr);
      chk($sformatf("row%0d.bus_strobe", i),32'(bus_strobe), 32'(vq[i].e_st));
      if (vq[i].e_we || vq[i].rst)
        chk($sformatf("row%0d.bus_wdata", i), bus_wdata, vq[i].e_wd);
      chk($sformatf("row%0d.ins_valid", i), 32'(ins_valid),  32'(vq[i].e_iv));
      chk($sformatf("row%0d.ins_err", i),   32'(ins_err),    32'(vq[i].e_ie));
      chk($sformatf("row%0d.ins_data", i),  ins_data,        vq[i].e_id);
      chk($sformatf("row%0d.dat_valid", i), 32'(dat_valid),  32'(vq[i].e_dv));
      chk($sformatf("row%0d.dat_err", i),   32'(dat_err),    32'(vq[i].e_de));
      chk($sformatf("row%0d.dat_rdata", i), dat_rdata,       vq[i].e_dd);
      chk($sformatf("row%0d.busy", i),      32'(busy),       32'(vq[i].e_busy));
    end

    // reset during a DAT WAIT aborts; stray valid ignored afterwards
    clr_in();
    dat_req = 1; dat_addr = 32'h600; dat_strobe = 4'hf;
    step();
    chk("rstw.en", 32'(bus_en), 1);
    step();
    chk("rstw.busy", 32'(busy), 1);
    rst = 1;
    step();
    chk("rst.bus_en", 32'(bus_en), 0);
    chk("rst.bus_we", 32'(bus_we), 0);
    chk("rst.bus_addr", bus_addr, 0);
    chk("rst.bus_wdata", bus_wdata, 0);
    chk("rst.bus_strobe", 32'(bus_strobe), 0);
    chk("rst.ins_valid", 32'(ins_valid), 0);
    chk("rst.ins_err", 32'(ins_err), 0);
    chk("rst.ins_data", ins_data, 0);
    chk("rst.dat_valid", 32'(dat_valid), 0);
    chk("rst.dat_err", 32'(dat_err), 0);
    chk("rst.dat_rdata", dat_rdata, 0);
    chk("rst.busy", 32'(busy), 0);
    clr_in();
    bus_valid = 1; bus_rdata = 32'h77;
    step();
    chk("stray1.dat_valid", 32'(dat_valid), 0);
    chk("stray1.busy", 32'(busy), 0);
    chk("stray1.dat_rdata", dat_rdata, 0);
    bus_valid = 0;

    // tie after reset, zero-wait memory: DAT, INS, DAT, INS
    ins_req = 1; ins_addr = 32'h0;
    dat_req = 1; dat_addr = 32'h200; dat_strobe = 4'hf;
    for (int k = 0; k < 4; k++) begin
      logic        exp_dat;
      logic [31:0] exp_addr;
      exp_dat  = (k % 2 == 0);
      exp_addr = exp_dat ? 32'h200 : 32'h0;
      step();
      chk($sformatf("tie%0d.bus_en", k), 32'(bus_en), 1);
      chk($sformatf("tie%0d.bus_addr", k), bus_addr, exp_addr);
      bus_valid = 1; bus_rdata = 32'hA0 + k;
      step();
      bus_valid = 0;
      chk($sformatf("tie%0d.dat_valid", k), 32'(dat_valid), 32'(exp_dat));
      chk($sformatf("tie%0d.ins_valid", k), 32'(ins_valid), 32'(!exp_dat));
      chk($sformatf("tie%0d.data", k), exp_dat ? dat_rdata : ins_data, 32'hA0 + k);
      step();
      chk($sformatf("tie%0d.idle", k), 32'(busy), 0);
    end

    // fetch timeout with TIMEOUT=8: err response 9 cycles after IDLE sees req
    clr_in();
    ins_req = 1; ins_addr = 32'h44;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("tmo%0d.ins_valid", k), 32'(ins_valid), 0);
      chk($sformatf("tmo%0d.busy", k), 32'(busy), 1);
      if (k <= 2) chk($sformatf("tmo%0d.bus_en", k), 32'(bus_en), (k == 1) ? 1 : 0);
    end
    step();
    chk("tmo9.ins_valid", 32'(ins_valid), 1);
    chk("tmo9.ins_err", 32'(ins_err), 1);
    chk("tmo9.ins_data", ins_data, 0);
    ins_req = 0;
    step();
    chk("tmo10.busy", 32'(busy), 0);
    chk("tmo10.ins_valid", 32'(ins_valid), 0);
    chk("tmo10.ins_err", 32'(ins_err), 0);
    bus_valid = 1; bus_rdata = 32'h99;
    step();
    bus_valid = 0;
    chk("stray2.ins_valid", 32'(ins_valid), 0);
    chk("stray2.dat_valid", 32'(dat_valid), 0);
    chk("stray2.busy", 32'(busy), 0);
    chk("stray2.ins_data", ins_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
